// File: rtl/jt10_regwr.sv
// jt10_regwr: register-write sequencer for a YM2610 (jt10) core.
// Requests {part, reg, val} are queued in a small FIFO on the clk domain and
// played onto the chip bus one at a time, paced by the chip clock enable:
// address strobe, fixed wait, busy-flag poll, data strobe, fixed wait.
module jt10_regwr #(
   parameter int FIFO_DEPTH = 4,    // request FIFO entries, power of two 2..16
   parameter int WAIT_ADDR  = 17,   // cen ticks after the address strobe (>= 1)
   parameter int WAIT_DATA  = 83,   // cen ticks after the data strobe (>= 1)
   parameter int POLL_MAX   = 255   // cen ticks allowed for the busy poll (>= 1)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cen,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_part,
   input  logic [7:0] req_reg,
   input  logic [7:0] req_val,
   output logic [7:0] din,
   output logic [1:0] addr,
   output logic       cs_n,
   output logic       wr_n,
   input  logic [7:0] chip_dout,
   output logic       busy,
   output logic       err_timeout
);

   // ------------------------------------------------------------------
   // Local sizes
   // ------------------------------------------------------------------
   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W   = PTR_W + 1;
   localparam int WAIT_HI = (WAIT_ADDR > WAIT_DATA) ? WAIT_ADDR : WAIT_DATA;
   localparam int TMR_TOP = (WAIT_HI > POLL_MAX) ? WAIT_HI : POLL_MAX;
   localparam int TMR_W   = $clog2(TMR_TOP + 1);

   // One queued register write
   typedef struct packed {
      logic       part;
      logic [7:0] rg;
      logic [7:0] val;
   } req_t;

   typedef enum logic [2:0] {
      IDLE,
      ADDR_WR,
      ADDR_WAIT,
      POLL,
      DATA_WR,
      DATA_WAIT
   } state_t;

   // ------------------------------------------------------------------
   // Request FIFO
   // ------------------------------------------------------------------
   req_t             mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   req_t             head;
   logic             fifo_empty;
   logic             push;
   logic             pop;

   state_t           state;
   logic [TMR_W-1:0] tmr;
   logic             cur_part;
   logic [7:0]       cur_val;

   // Only the busy bit of the status byte matters here
   logic             unused_status;
   assign unused_status = ^chip_dout[6:0];

   // FIFO status and handshake; the pop is tied to the FSM leaving IDLE
   always_comb begin
      fifo_empty = (count == '0);
      req_ready  = (count != CNT_W'(FIFO_DEPTH));
      push       = req_valid && req_ready;
      pop        = cen && (state == IDLE) && !fifo_empty;
      head       = mem[rd_ptr];
      busy       = !fifo_empty || (state != IDLE);
   end

   // FIFO storage: written on accepted requests only
   // NOTE: the storage array has no reset; validity is carried by count and
   // the pointers, so clearing the data would only cost logic.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= req_t'{part: req_part, rg: req_reg, val: req_val};
      end
   end

   // FIFO pointers and occupancy; a push and pop on one edge cancel out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // pointers wrap naturally because the depth is a power of two
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Chip-bus sequencer
   // ------------------------------------------------------------------
   // Bus FSM: advances on cen ticks only, every chip-bus output registered
   // NOTE: all state and bus outputs use non-blocking assignments so every
   // branch below sees the values from before this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         tmr         <= '0;
         cur_part    <= 1'b0;
         cur_val     <= 8'h00;
         din         <= 8'h00;
         addr        <= 2'b00;
         cs_n        <= 1'b1;
         wr_n        <= 1'b1;
         err_timeout <= 1'b0;
      end else if (cen) begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  // address strobe: register number on the even port
                  cur_part <= head.part;
                  cur_val  <= head.val;
                  addr     <= {head.part, 1'b0};
                  din      <= head.rg;
                  cs_n     <= 1'b0;
                  wr_n     <= 1'b0;
                  state    <= ADDR_WR;
               end
            end

            ADDR_WR: begin
               // strobe has been low for exactly one cen period
               cs_n  <= 1'b1;
               wr_n  <= 1'b1;
               tmr   <= TMR_W'(WAIT_ADDR);
               state <= ADDR_WAIT;
            end

            ADDR_WAIT: begin
               if (tmr <= TMR_W'(1)) begin
                  // select the chip again (no write) to watch the busy flag
                  addr  <= {cur_part, 1'b0};
                  cs_n  <= 1'b0;
                  wr_n  <= 1'b1;
                  tmr   <= TMR_W'(POLL_MAX);
                  state <= POLL;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end

            POLL: begin
               if (!chip_dout[7] || (tmr <= TMR_W'(1))) begin
                  // chip ready, or gave up waiting: issue the data strobe
                  if (chip_dout[7]) begin
                     err_timeout <= 1'b1;
                  end
                  addr  <= {cur_part, 1'b1};
                  din   <= cur_val;
                  cs_n  <= 1'b0;
                  wr_n  <= 1'b0;
                  state <= DATA_WR;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end

            DATA_WR: begin
               cs_n  <= 1'b1;
               wr_n  <= 1'b1;
               tmr   <= TMR_W'(WAIT_DATA);
               state <= DATA_WAIT;
            end

            DATA_WAIT: begin
               if (tmr <= TMR_W'(1)) begin
                  state <= IDLE;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end

            default: begin
               cs_n  <= 1'b1;
               wr_n  <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jt10_regwr.sv
// tb_jt10_regwr: directed and random register-write batches for jt10_regwr.
// A chip model answers the busy poll from a per-write plan; a monitor logs
// strobes, poll starts and busy falls in cen ticks, and each batch is scored
// against a transaction-level timing model.
module tb_jt10_regwr;
   localparam int WA    = 17;
   localparam int WD    = 83;
   localparam int PM    = 255;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cen = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_part = 1'b0;
   logic [7:0] req_reg = 8'h00;
   logic [7:0] req_val = 8'h00;
   logic [7:0] chip_dout = 8'h00;
   logic       req_ready;
   logic [7:0] din;
   logic [1:0] addr;
   logic       cs_n;
   logic       wr_n;
   logic       busy;
   logic       err_timeout;

   jt10_regwr #(
      .FIFO_DEPTH(DEPTH),
      .WAIT_ADDR (WA),
      .WAIT_DATA (WD),
      .POLL_MAX  (PM)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cen        (cen),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_part   (req_part),
      .req_reg    (req_reg),
      .req_val    (req_val),
      .din        (din),
      .addr       (addr),
      .cs_n       (cs_n),
      .wr_n       (wr_n),
      .chip_dout  (chip_dout),
      .busy       (busy),
      .err_timeout(err_timeout)
   );

   typedef struct {
      logic       part;
      logic [7:0] rg;
      logic [7:0] val;
      int         b;      // poll samples for which the chip reports busy
   } txn_t;

   typedef struct {
      int         tick;
      logic [1:0] a;
      logic [7:0] d;
   } strobe_t;

   int      checks = 0;
   int      failures = 0;
   int      tick = 0;
   logic    last_cen = 1'b0;
   int      cen_mode = 0;     // 0: cen driven by main, 1: every 4 clk, 2: random
   int      viol = 0;
   int      busy_left = 0;
   logic    err_exp = 1'b0;
   int      sb = 0;
   int      pb = 0;
   int      fb = 0;
   strobe_t strobes[$];
   int      polls[$];
   int      falls[$];
   int      plan[$];
   txn_t    exp_q[$];

   // clock
   initial begin
      forever #5 clk = ~clk;
   end

   // remember whether the last rising edge was a cen tick
   initial begin
      forever begin
         @(posedge clk);
         last_cen = cen;
      end
   end

   // cen pattern generator
   initial begin : cen_gen
      int ph;
      ph = 0;
      forever begin
         @(negedge clk);
         if (cen_mode == 1) begin
            ph  = (ph + 1) % 4;
            cen = (ph == 0);
         end else if (cen_mode == 2) begin
            cen = ($urandom_range(0, 2) == 0);
         end
      end
   end

   // bus monitor and chip busy model
   initial begin : mon
      logic       pw, pc, pbz, ppoll, open;
      int         st;
      logic [1:0] sa;
      logic [7:0] sd;
      strobe_t    s;
      pw = 1'b1; pc = 1'b1; pbz = 1'b0; ppoll = 1'b0; open = 1'b0;
      st = 0; sa = 2'b00; sd = 8'h00;
      forever begin
         @(negedge clk);
         if (last_cen) tick++;
         if (rst) begin
            pw = 1'b1; pc = 1'b1; pbz = 1'b0; ppoll = 1'b0; open = 1'b0;
            busy_left = 0;
         end else begin
            if (last_cen && ppoll && busy_left > 0) busy_left--;
            if (pw === 1'b1 && wr_n === 1'b0) begin
               s.tick = tick; s.a = addr; s.d = din;
               strobes.push_back(s);
               open = 1'b1; st = tick; sa = addr; sd = din;
               if (addr[0] === 1'b0) begin
                  if (plan.size() > 0) busy_left = plan.pop_front();
                  else busy_left = 0;
               end
            end
            if (wr_n === 1'b0 && cs_n !== 1'b0) viol++;
            if (open && wr_n === 1'b0 && (addr !== sa || din !== sd)) viol++;
            if (open && wr_n === 1'b1) begin
               if (tick - st != 1) viol++;
               open = 1'b0;
            end
            if (pc === 1'b1 && cs_n === 1'b0 && wr_n === 1'b1) polls.push_back(tick);
            if (pbz === 1'b1 && busy === 1'b0) falls.push_back(tick);
            pw = wr_n; pc = cs_n; pbz = busy;
            ppoll = (cs_n === 1'b0 && wr_n === 1'b1);
         end
         chip_dout = {busy_left != 0, 7'($urandom)};
      end
   end

   // hang guard
   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic add(input logic p, input logic [7:0] rg, input logic [7:0] val, input int b);
      txn_t t;
      t.part = p; t.rg = rg; t.val = val; t.b = b;
      exp_q.push_back(t);
      plan.push_back(b);
      if (b >= PM) err_exp = 1'b1;
   endtask

   task automatic push(input logic p, input logic [7:0] rg, input logic [7:0] val,
                       input logic exp_rdy, input string tag);
      @(negedge clk); #1;
      req_valid = 1'b1; req_part = p; req_reg = rg; req_val = val;
      check(tag, req_ready, exp_rdy);
   endtask

   task automatic stop_push();
      @(negedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic mark();
      sb = strobes.size(); pb = polls.size(); fb = falls.size();
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (busy !== 1'b0 && n < 20000);
      check({tag, "_idle"}, busy, 1'b0);
   endtask

   task automatic check_batch(input string tag);
      int n, p, a, d, prev_d;
      n = exp_q.size();
      prev_d = 0; d = 0;
      check({tag, "_strobes"}, strobes.size() - sb, 2 * n);
      check({tag, "_polls"}, polls.size() - pb, n);
      if (strobes.size() - sb == 2 * n && polls.size() - pb == n) begin
         for (int i = 0; i < n; i++) begin
            p = (exp_q[i].b + 1 < PM) ? exp_q[i].b + 1 : PM;
            a = strobes[sb + 2*i].tick;
            d = strobes[sb + 2*i + 1].tick;
            check($sformatf("%s_aaddr%0d", tag, i), strobes[sb + 2*i].a, {exp_q[i].part, 1'b0});
            check($sformatf("%s_areg%0d", tag, i), strobes[sb + 2*i].d, exp_q[i].rg);
            check($sformatf("%s_daddr%0d", tag, i), strobes[sb + 2*i + 1].a, {exp_q[i].part, 1'b1});
            check($sformatf("%s_dval%0d", tag, i), strobes[sb + 2*i + 1].d, exp_q[i].val);
            check($sformatf("%s_pollgap%0d", tag, i), polls[pb + i] - a, 1 + WA);
            check($sformatf("%s_datagap%0d", tag, i), d - a, 1 + WA + p);
            if (i > 0) check($sformatf("%s_nextgap%0d", tag, i), a - prev_d, 2 + WD);
            prev_d = d;
         end
      end
      check({tag, "_falls"}, falls.size() - fb, 1);
      if (falls.size() - fb == 1) check({tag, "_busylow"}, falls[fb] - d, 1 + WD);
      check({tag, "_err"}, err_timeout, err_exp);
      check({tag, "_protocol"}, viol, 0);
   endtask

   task automatic run_batch(input int mode, input string tag);
      cen_mode = mode;
      wait_idle(tag);
      cen_mode = 0;
      cen = 1'b0;
      check_batch(tag);
      exp_q.delete();
   endtask

   initial begin : main
      int n, n0;
      logic [7:0] r, v;
      logic pp;

      // reset state
      #2 rst = 1'b1;
      #1;
      check("rst_cs_n", cs_n, 1'b1);
      check("rst_wr_n", wr_n, 1'b1);
      check("rst_addr", addr, 2'b00);
      check("rst_din", din, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_err", err_timeout, 1'b0);
      check("rst_ready", req_ready, 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // single write, part 0
      mark();
      add(1'b0, 8'h28, 8'hF1, 0);
      push(1'b0, 8'h28, 8'hF1, 1'b1, "single_rdy");
      stop_push();
      run_batch(1, "single");

      // part select
      mark();
      add(1'b1, 8'h10, 8'h5A, 0);
      push(1'b1, 8'h10, 8'h5A, 1'b1, "part_rdy");
      stop_push();
      run_batch(1, "part");

      // FIFO full with cen stopped, then drained in order
      mark();
      for (int i = 0; i < 5; i++) begin
         v = 8'($urandom);
         push(1'(i), 8'h30 + 8'(i), v, (i < DEPTH), $sformatf("full_rdy%0d", i));
         if (i < DEPTH) add(1'(i), 8'h30 + 8'(i), v, 0);
      end
      stop_push();
      check("full_after", req_ready, 1'b0);
      repeat (30) @(negedge clk);
      #1;
      check("hold_strobes", strobes.size() - sb, 0);
      check("hold_cs_n", cs_n, 1'b1);
      check("hold_busy", busy, 1'b1);
      run_batch(1, "fifo");

      // busy for 10 poll samples
      mark();
      add(1'b0, 8'hA4, 8'h22, 10);
      push(1'b0, 8'hA4, 8'h22, 1'b1, "poll10_rdy");
      stop_push();
      run_batch(1, "poll10");

      // busy stuck: timeout after POLL_MAX samples
      mark();
      add(1'b1, 8'h1C, 8'h3F, 1000);
      push(1'b1, 8'h1C, 8'h3F, 1'b1, "tmo_rdy");
      stop_push();
      run_batch(1, "timeout");

      // error flag stays set across a clean write
      mark();
      add(1'b0, 8'h07, 8'h11, 0);
      push(1'b0, 8'h07, 8'h11, 1'b1, "sticky_rdy");
      stop_push();
      run_batch(1, "sticky");

      // simultaneous push and pop at count 3
      mark();
      for (int i = 0; i < 3; i++) begin
         v = 8'($urandom);
         add(1'b0, 8'h40 + 8'(i), v, int'($urandom_range(0, 3)));
         push(1'b0, 8'h40 + 8'(i), v, 1'b1, $sformatf("simul_fill%0d", i));
      end
      stop_push();
      @(negedge clk); #1;
      cen = 1'b1;
      req_valid = 1'b1; req_part = 1'b1; req_reg = 8'h43; req_val = 8'hC3;
      add(1'b1, 8'h43, 8'hC3, 1);
      check("simul_rdy_before", req_ready, 1'b1);
      @(negedge clk); #1;
      cen = 1'b0;
      req_valid = 1'b0;
      check("simul_rdy_after", req_ready, 1'b1);
      add(1'b0, 8'h44, 8'h99, 0);
      push(1'b0, 8'h44, 8'h99, 1'b1, "simul_push4");
      stop_push();
      check("simul_full", req_ready, 1'b0);
      push(1'b1, 8'h45, 8'h00, 1'b0, "simul_reject");
      stop_push();
      run_batch(1, "simul");

      // random batches under a random cen pattern
      for (int k = 0; k < 3; k++) begin
         mark();
         n = int'($urandom_range(1, DEPTH));
         for (int i = 0; i < n; i++) begin
            pp = 1'($urandom);
            r  = 8'($urandom);
            v  = 8'($urandom);
            add(pp, r, v, ($urandom_range(0, 7) == 0) ? 300 : int'($urandom_range(0, 6)));
            push(pp, r, v, 1'b1, $sformatf("rand%0d_rdy%0d", k, i));
         end
         stop_push();
         run_batch(2, $sformatf("rand%0d", k));
      end

      // reset in the middle of a data strobe
      mark();
      for (int i = 0; i < 3; i++) begin
         add(1'(i), 8'h60 + 8'(i), 8'h70 + 8'(i), 0);
         push(1'(i), 8'h60 + 8'(i), 8'h70 + 8'(i), 1'b1, $sformatf("mid_rdy%0d", i));
      end
      stop_push();
      cen_mode = 1;
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (!(wr_n === 1'b0 && addr[0] === 1'b1) && n < 5000);
      check("mid_found_data_strobe", (wr_n === 1'b0 && addr[0] === 1'b1), 1'b1);
      #2 rst = 1'b1;
      #1;
      check("mid_cs_n", cs_n, 1'b1);
      check("mid_wr_n", wr_n, 1'b1);
      check("mid_busy", busy, 1'b0);
      check("mid_ready", req_ready, 1'b1);
      check("mid_err", err_timeout, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      err_exp = 1'b0;
      plan.delete();
      exp_q.delete();
      n0 = strobes.size();
      repeat (600) @(negedge clk);
      #1;
      check("mid_no_strobes", strobes.size() - n0, 0);
      check("mid_busy_after", busy, 1'b0);
      check("mid_cs_after", cs_n, 1'b1);
      check("mid_protocol", viol, 0);
      cen_mode = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
